// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared state encoding, default parameters and widths for the
// FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam int N_REQ_DEF     = 4;
    localparam int DATA_W_DEF    = 16;
    localparam int MAX_RETRY_DEF = 3;
    localparam int STAT_W        = 16;
    localparam int RETRY_W       = 4;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_if: write side of the team's synchronous FIFO. The arbiter is the
// master (drives wr_en/data_in); the FIFO is the slave (returns status).
interface fifo_wr_if
    import fifo_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              full;
    logic              wr_ack;
    logic              overflow;

    modport master (
        output wr_en,
        output data_in,
        input  full,
        input  wr_ack,
        input  overflow
    );

    modport slave (
        input  wr_en,
        input  data_in,
        output full,
        output wr_ack,
        output overflow
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_arb_pick.sv
// rr_arb_pick: combinational round-robin pick. Returns the first set request
// bit found scanning upward from i_ptr with wrap-around.
module rr_arb_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int PTR_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [PTR_W-1:0] o_grant,
    output logic             o_valid
);

    logic [PTR_W:0] w_pos;

    // NOTE: combinational logic uses blocking '=' with a default assigned
    // first, so every path drives every output and no latch is inferred.
    always_comb begin
        o_valid = 1'b0;
        o_grant = '0;
        w_pos   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_pos = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_pos >= (PTR_W+1)'(N_REQ)) begin
                w_pos = w_pos - (PTR_W+1)'(N_REQ);
            end
            if (!o_valid && i_req[w_pos[PTR_W-1:0]]) begin
                o_valid = 1'b1;
                o_grant = w_pos[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one FIFO write port among N_REQ
// requesters, with bounded retry. Optional counters under FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_RETRY = MAX_RETRY_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*DATA_W-1:0]    i_req_data,
    output logic [N_REQ-1:0]           o_ack,
    output logic [N_REQ-1:0]           o_nack,
    output logic                       o_busy,
`ifdef FIFO_ARB_STATS_EN
    output logic [N_REQ*STAT_W-1:0]    o_acc_cnt,
    output logic [STAT_W-1:0]          o_drop_cnt,
`endif
    fifo_wr_if.master                  fifo_if
);

    localparam int PTR_W = idx_w(N_REQ);

    arb_state_e         r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_idx;
    logic [RETRY_W-1:0] r_retry;
    logic [DATA_W-1:0]  r_data;
    logic [N_REQ-1:0]   r_ack;
    logic [N_REQ-1:0]   r_nack;
    logic               r_wr_en;
    logic               r_busy;

    logic [PTR_W-1:0]   w_grant;
    logic               w_valid;
    logic [PTR_W-1:0]   w_next_idx;
    logic               w_last_try;
    logic               w_refused;
    logic [DATA_W-1:0]  w_sel_data;

    rr_arb_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    assign w_sel_data = i_req_data[int'(w_grant)*DATA_W +: DATA_W];
    assign w_next_idx = (r_idx == PTR_W'(N_REQ-1)) ? '0 : r_idx + 1'b1;
    assign w_last_try = ((r_retry + 1'b1) == RETRY_W'(MAX_RETRY));
    // wr_ack wins over a simultaneous overflow, so any cycle without wr_ack is a refusal.
    assign w_refused  = fifo_if.overflow | ~fifo_if.wr_ack;

    // NOTE: sequential state uses non-blocking '<=' so every register sees
    // the pre-edge values of the others, matching flip-flop behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_retry <= '0;
            r_data  <= '0;
            r_ack   <= '0;
            r_nack  <= '0;
            r_wr_en <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ack  <= '0;
            r_nack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_valid && !fifo_if.full) begin
                        r_idx   <= w_grant;
                        r_data  <= w_sel_data;
                        r_wr_en <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_wr_en <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    if (fifo_if.wr_ack) begin
                        r_ack[r_idx] <= 1'b1;
                        r_ptr        <= w_next_idx;
                        r_retry      <= '0;
                    end else if (w_refused) begin
                        if (w_last_try) begin
                            r_nack[r_idx] <= 1'b1;
                            r_ptr         <= w_next_idx;
                            r_retry       <= '0;
                        end else begin
                            // Pointer stays on the refused requester so it retries first.
                            r_retry <= r_retry + 1'b1;
                            r_ptr   <= r_idx;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_if.wr_en   = r_wr_en;
    assign fifo_if.data_in = r_data;
    assign o_ack           = r_ack;
    assign o_nack          = r_nack;
    assign o_busy          = r_busy;

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_W-1:0] r_acc_cnt [N_REQ];
    logic [STAT_W-1:0] r_drop_cnt;

    // NOTE: the counter array is a handful of flops, not a RAM, so it takes
    // the async reset like any other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                r_acc_cnt[i] <= '0;
            end
            r_drop_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (r_ack[i] && (r_acc_cnt[i] != '1)) begin
                    r_acc_cnt[i] <= r_acc_cnt[i] + 1'b1;
                end
            end
            if ((|r_nack) && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_acc_out
        assign o_acc_cnt[g*STAT_W +: STAT_W] = r_acc_cnt[g];
    end
    assign o_drop_cnt = r_drop_cnt;
`endif

endmodule
